ehl_gpio_bank: RTL and testbench
================================

# ehl_gpio_bank

Parametrised GPIO bank with a small register interface. It provides an output data register with set/clear/invert access, a per-bit direction register, input synchronisation and a per-bit interrupt engine (level or edge, selectable polarity, both-edge option). An optional debounce filter can be compiled in. It sits between a bus-slave adapter (APB/AHB bridge) and the chip pad ring.

## Interface
- WIDTH, 32, number of GPIO bits (1..32)
- REG_INIT, 0, reset value of OUT register
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- DEBOUNCE_CNT, 16, stable cycles required by debounce filter (>=2; used only with EHL_GPIO_DEBOUNCE_EN)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- reg_wr  input  1  write strobe, one-cycle
- reg_rd  input  1  read strobe, one-cycle
- reg_addr  input  4  register index
- reg_wdata  input  WIDTH  write data
- reg_rdata  output  WIDTH  read data, registered
- gpio_in  input  WIDTH  asynchronous pad inputs
- gpio_out  output  WIDTH  pad output data (= OUT)
- gpio_oe  output  WIDTH  pad output enable (= DIR, 1 = drive)
- irq  output  1  registered interrupt request

## Operation
- Register map (reg_addr):
  - 0: OUT (rw), full write.
  - 1: OUT_SET (w), OUT |= wdata.
  - 2: OUT_CLR (w), OUT &= ~wdata.
  - 3: OUT_INV (w), OUT ^= wdata. Reads of 1..3 return OUT.
  - 4: DIR (rw).
  - 5: IRQ_EN (rw).
  - 6: IRQ_TYPE (rw; 0 level, 1 edge).
  - 7: IRQ_POL (rw; level: 1 high/0 low; edge: 1 rising/0 falling).
  - 8: IRQ_BOTH (rw; edge type only, 1 = both edges, POL ignored).
  - 9: IN (ro), filtered input.
  - 10: IRQ_STAT (rw1c).
  - 11..15: reserved; reads return 0, writes are ignored.
- Only one register is accessed per cycle, so set/clr/inv never collide. A write to a read-only address is ignored.
- Input path: gpio_in passes through SYNC_STAGES flops to give sync_in, then the optional debounce filter to give filt_in. in_prev is filt_in delayed by one cycle.
- Events per bit:
  - Level type: condition = (filt_in == POL).
  - Edge type: rise = filt_in & ~in_prev, fall = ~filt_in & in_prev. Event = BOTH ? rise|fall : (POL ? rise : fall).
- IRQ_STAT bit is sticky. It sets on any event, whether or not the bit is enabled in IRQ_EN.
  - W1C clears the bit.
  - When an event and a W1C to the same bit occur in the same cycle, set wins.
  - In level type the bit re-sets every cycle while the condition holds.
- irq <= |(IRQ_STAT & IRQ_EN), registered.
- Edge arm: a counter blocks edge events until SYNC_STAGES+1 cycles after reset deasserts, so a pin held high through reset raises no rising event. Level events are not blocked.
- reg_rdata updates only on reg_rd and holds its value otherwise.

## Timing
- Reset values: OUT=REG_INIT[WIDTH-1:0], DIR/IRQ_EN/IRQ_TYPE/IRQ_POL/IRQ_BOTH/IRQ_STAT=0, synchroniser and in_prev=0, reg_rdata=0, irq=0, gpio_out=REG_INIT, gpio_oe=0.
- Asserting reset mid-operation restores all of the above on the next edge, including the arm counter and the debounce counters.
- Register writes take effect at the edge where reg_wr is sampled. gpio_out and gpio_oe change on that same edge.
- Read latency is 1: reg_rdata is valid the cycle after reg_rd.
- Without debounce, a pin change settled before edge 0:
  - IN readable (sync_in) after edge SYNC_STAGES.
  - IRQ_STAT set at edge SYNC_STAGES+1.
  - irq high at edge SYNC_STAGES+2.
- Clearing IRQ_STAT or IRQ_EN drops irq one edge later.

## Configuration
- EHL_GPIO_DEBOUNCE_EN defined: each bit has a counter of width clog2(DEBOUNCE_CNT).
  - The counter increments while sync_in != filt_in and clears when they are equal.
  - When the count reaches DEBOUNCE_CNT-1 and they still differ, filt_in <= sync_in and the counter clears.
  - Glitches shorter than DEBOUNCE_CNT cycles are rejected.
  - This adds DEBOUNCE_CNT cycles of latency.
- Not defined: filt_in = sync_in, with no counters and no added latency.

## Test plan
- Reset with REG_INIT=32'hA5: gpio_out=32'hA5, gpio_oe=0, irq=0. Then OUT_SET 32'h0F00, OUT_CLR 32'h0005, OUT_INV 32'hFF: gpio_out reads 32'h0F00 ^ 32'hA0 ^ 32'hFF = 32'h0F5F.
- IRQ_EN[3]=1, TYPE[3]=1, POL[3]=1, SYNC_STAGES=2: raise gpio_in[3] -> IRQ_STAT[3]=1 at edge 3 and irq=1 at edge 4. Falling gpio_in[3] -> no new event.
- Edge type with BOTH[0]=1: toggle gpio_in[0] high then low, clearing IRQ_STAT between the toggles -> status sets on each edge. W1C issued in the same cycle as a new edge -> bit stays 1.
- Level-low, IRQ_EN[7]=1 with pin held low: W1C of bit 7 -> bit reads 1 again next cycle. Pin released high, then W1C -> bit stays 0 and irq falls.
- gpio_in[1] held high through reset, edge type, rising polarity -> no IRQ_STAT after reset release. A later low-to-high pulse -> event.
- With EHL_GPIO_DEBOUNCE_EN and DEBOUNCE_CNT=16:
  - A 10-cycle pulse on gpio_in[2] -> IN[2] unchanged and no event.
  - A 20-cycle pulse -> IN[2]=1 after SYNC_STAGES+16 cycles.

Source files
------------

// File: rtl/ehl_gpio_bank.sv
// ehl_gpio_bank - parametrised GPIO bank with a small register interface.
//
// Purpose: sits between a bus-slave adapter and the pad ring. Provides an
// output data register with set/clear/invert aliases, a per-bit direction
// register, a multi-flop input synchroniser, an optional debounce filter and
// a per-bit sticky interrupt engine (level or edge, polarity, both-edge).
//
// Ports:
//   clk        single clock, everything on the rising edge
//   reset      synchronous active-high reset
//   reg_wr     one-cycle write strobe
//   reg_rd     one-cycle read strobe
//   reg_addr   register index (0..15)
//   reg_wdata  write data
//   reg_rdata  registered read data, valid the cycle after reg_rd
//   gpio_in    asynchronous pad inputs
//   gpio_out   pad output data (OUT register)
//   gpio_oe    pad output enable (DIR register, 1 = drive)
//   irq        registered interrupt request
//
// Configuration macro: EHL_GPIO_DEBOUNCE_EN compiles in a per-bit debounce
// filter of DEBOUNCE_CNT stable cycles. Without it the filtered input is the
// synchroniser output.

module ehl_gpio_bank #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] REG_INIT     = 32'h0,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [3:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] OUT_INIT = REG_INIT[WIDTH-1:0];
  localparam int unsigned      ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  localparam logic [3:0] ADDR_OUT      = 4'd0;
  localparam logic [3:0] ADDR_OUT_SET  = 4'd1;
  localparam logic [3:0] ADDR_OUT_CLR  = 4'd2;
  localparam logic [3:0] ADDR_OUT_INV  = 4'd3;
  localparam logic [3:0] ADDR_DIR      = 4'd4;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd5;
  localparam logic [3:0] ADDR_IRQ_TYPE = 4'd6;
  localparam logic [3:0] ADDR_IRQ_POL  = 4'd7;
  localparam logic [3:0] ADDR_IRQ_BOTH = 4'd8;
  localparam logic [3:0] ADDR_IN       = 4'd9;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd10;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in, filt_in;
  logic [WIDTH-1:0] in_prev_q, in_prev_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d, irq_type_q, irq_type_d;
  logic [WIDTH-1:0] irq_pol_q, irq_pol_d, irq_both_q, irq_both_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d, rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise, fall, edge_ev, level_ev, event_v, w1c;

  // Synchroniser shift chain; the last stage is the metastability-safe input.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef EHL_GPIO_DEBOUNCE_EN
  localparam int unsigned     DB_W   = $clog2(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CNT - 1);

  logic [WIDTH-1:0] filt_q, filt_d;
  logic [DB_W-1:0]  db_cnt_q [WIDTH];
  logic [DB_W-1:0]  db_cnt_d [WIDTH];

  // Each bit counts consecutive cycles where the synchronised input disagrees
  // with the filtered value; any agreement restarts the count, so only a level
  // held for DEBOUNCE_CNT cycles is accepted.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < WIDTH; b++) begin
      db_cnt_d[b] = '0;
      if (sync_in[b] != filt_q[b]) begin
        if (db_cnt_q[b] == DB_MAX) filt_d[b] = sync_in[b];
        else                       db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int b = 0; b < WIDTH; b++) db_cnt_q[b] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int b = 0; b < WIDTH; b++) db_cnt_q[b] <= db_cnt_d[b];
    end
  end

  assign filt_in = filt_q;
`else
  assign filt_in = sync_in;
`endif

  // Event detection. Edge events stay blocked until the arm counter has seen
  // the synchroniser flush after reset, so a pin held high through reset does
  // not look like a rising edge. Level events are never blocked.
  always_comb begin
    rise     = filt_in & ~in_prev_q;
    fall     = ~filt_in & in_prev_q;
    edge_ev  = (irq_both_q & (rise | fall)) |
               (~irq_both_q & ((irq_pol_q & rise) | (~irq_pol_q & fall)));
    level_ev = ~(filt_in ^ irq_pol_q);
    if (arm_cnt_q != ARM_DONE) edge_ev = '0;
    event_v  = (irq_type_q & edge_ev) | (~irq_type_q & level_ev);
  end

  // Register writes, sticky status with set-over-clear priority, interrupt
  // request and the read mux.
  always_comb begin
    in_prev_d  = filt_in;
    arm_cnt_d  = (arm_cnt_q == ARM_DONE) ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    out_d      = out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_type_d = irq_type_q;
    irq_pol_d  = irq_pol_q;
    irq_both_d = irq_both_q;
    w1c        = '0;
    if (reg_wr) begin
      case (reg_addr)
        ADDR_OUT:      out_d      = reg_wdata;
        ADDR_OUT_SET:  out_d      = out_q | reg_wdata;
        ADDR_OUT_CLR:  out_d      = out_q & ~reg_wdata;
        ADDR_OUT_INV:  out_d      = out_q ^ reg_wdata;
        ADDR_DIR:      dir_d      = reg_wdata;
        ADDR_IRQ_EN:   irq_en_d   = reg_wdata;
        ADDR_IRQ_TYPE: irq_type_d = reg_wdata;
        ADDR_IRQ_POL:  irq_pol_d  = reg_wdata;
        ADDR_IRQ_BOTH: irq_both_d = reg_wdata;
        ADDR_IRQ_STAT: w1c        = reg_wdata;
        default:       ;
      endcase
    end
    irq_stat_d = (irq_stat_q & ~w1c) | event_v;
    irq_d      = |(irq_stat_q & irq_en_q);
    rdata_d    = rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        ADDR_OUT, ADDR_OUT_SET,
        ADDR_OUT_CLR, ADDR_OUT_INV: rdata_d = out_q;
        ADDR_DIR:                   rdata_d = dir_q;
        ADDR_IRQ_EN:                rdata_d = irq_en_q;
        ADDR_IRQ_TYPE:              rdata_d = irq_type_q;
        ADDR_IRQ_POL:               rdata_d = irq_pol_q;
        ADDR_IRQ_BOTH:              rdata_d = irq_both_q;
        ADDR_IN:                    rdata_d = filt_in;
        ADDR_IRQ_STAT:              rdata_d = irq_stat_q;
        default:                    rdata_d = '0;
      endcase
    end
  end

  // All bank state, restored together by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev_q  <= '0;
      arm_cnt_q  <= '0;
      out_q      <= OUT_INIT;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
      irq_both_q <= '0;
      irq_stat_q <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      in_prev_q  <= in_prev_d;
      arm_cnt_q  <= arm_cnt_d;
      out_q      <= out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_type_q <= irq_type_d;
      irq_pol_q  <= irq_pol_d;
      irq_both_q <= irq_both_d;
      irq_stat_q <= irq_stat_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign reg_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ehl_gpio_bank.sv
// tb_ehl_gpio_bank - self-checking bench for ehl_gpio_bank.
// Register access is table driven; interrupt corner cases are hand-written
// sequences; a randomized phase compares against a cycle-indexed model built
// from the pin history. Debounce-specific sequences run when
// EHL_GPIO_DEBOUNCE_EN is defined.

module tb_ehl_gpio_bank;

  localparam int          WIDTH        = 32;
  localparam logic [31:0] REG_INIT     = 32'hA5;
  localparam int          SYNC_STAGES  = 2;
  localparam int          DEBOUNCE_CNT = 16;

  logic        clk = 1'b0;
  logic        reset, reg_wr, reg_rd;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata, gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  ehl_gpio_bank #(
    .WIDTH(WIDTH), .REG_INIT(REG_INIT),
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the randomized phase.
  logic [31:0] m_out, m_dir, m_en, m_type, m_pol, m_both, m_stat, m_rdata;
  logic        m_irq;
  logic [31:0] pin_hist[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic regWrite(input logic [3:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic regRead(input logic [3:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic addVec(input bit w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] eo, input logic [31:0] eoe, input logic [31:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp_out = eo; v.exp_oe = eoe; v.exp_rdata = er;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] rd;
    if (v.is_wr) regWrite(v.addr, v.data);
    else begin
      regRead(v.addr, rd);
      checkOutput($sformatf("vec%0d rdata", idx), rd, v.exp_rdata);
    end
    checkOutput($sformatf("vec%0d gpio_out", idx), gpio_out, v.exp_out);
    checkOutput($sformatf("vec%0d gpio_oe", idx), gpio_oe, v.exp_oe);
  endtask

  // Filtered input after edge n (edges counted from reset release): the pin
  // value sampled SYNC_STAGES-1 edges earlier, zero before the chain fills.
  function automatic logic [31:0] filtAfter(input int n);
    int k;
    k = n - SYNC_STAGES + 1;
    if (k >= 1) return pin_hist[k];
    return 32'h0;
  endfunction

  task automatic modelStep(input int n, input logic wr, input logic rd,
                           input logic [3:0] a, input logic [31:0] d);
    logic [31:0] cur, prv, rise, fall, eev, ev, w1c;
    cur  = filtAfter(n - 1);
    prv  = filtAfter(n - 2);
    rise = cur & ~prv;
    fall = ~cur & prv;
    eev  = 32'h0;
    for (int b = 0; b < 32; b++) begin
      if (m_both[b])     eev[b] = rise[b] | fall[b];
      else if (m_pol[b]) eev[b] = rise[b];
      else               eev[b] = fall[b];
    end
    if (n < SYNC_STAGES + 2) eev = 32'h0;
    ev = 32'h0;
    for (int b = 0; b < 32; b++)
      ev[b] = m_type[b] ? eev[b] : (cur[b] == m_pol[b]);
    if (rd) begin
      case (a)
        0, 1, 2, 3: m_rdata = m_out;
        4: m_rdata = m_dir;
        5: m_rdata = m_en;
        6: m_rdata = m_type;
        7: m_rdata = m_pol;
        8: m_rdata = m_both;
        9: m_rdata = cur;
        10: m_rdata = m_stat;
        default: m_rdata = 32'h0;
      endcase
    end
    m_irq = (m_stat & m_en) != 0;
    w1c = 32'h0;
    if (wr) begin
      case (a)
        0: m_out = d;
        1: m_out = m_out | d;
        2: m_out = m_out & ~d;
        3: m_out = m_out ^ d;
        4: m_dir = d;
        5: m_en = d;
        6: m_type = d;
        7: m_pol = d;
        8: m_both = d;
        10: w1c = d;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~w1c) | ev;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    gpio_in = 32'h0;

    // ---------------- register access table ----------------
    addVec(0, 0,  32'h0,        32'h0000_00A5, 32'h0, 32'h0000_00A5);
    addVec(1, 1,  32'h0000_0F00, 32'h0000_0FA5, 32'h0, 32'h0);
    addVec(1, 2,  32'h0000_0005, 32'h0000_0FA0, 32'h0, 32'h0);
    addVec(1, 3,  32'h0000_00FF, 32'h0000_0F5F, 32'h0, 32'h0);
    addVec(0, 3,  32'h0,        32'h0000_0F5F, 32'h0, 32'h0000_0F5F);
    addVec(1, 4,  32'hFFFF_0000, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 4,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'hFFFF_0000);
    addVec(1, 11, 32'hDEAD_BEEF, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 11, 32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(1, 9,  32'h1234_5678, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 9,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(1, 6,  32'hA5A5_A5A5, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 6,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'hA5A5_A5A5);
    addVec(1, 7,  32'h3C3C_3C3C, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 7,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h3C3C_3C3C);
    addVec(1, 8,  32'h0F0F_0F0F, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 8,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h0F0F_0F0F);
    addVec(1, 5,  32'h1234_5678, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 5,  32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h1234_5678);
    // every bit started level-low with the pins low, so all status is set
    addVec(0, 10, 32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'hFFFF_FFFF);
    // after W1C only level-low bits (~TYPE & ~POL) re-set
    addVec(1, 10, 32'hFFFF_FFFF, 32'h0000_0F5F, 32'hFFFF_0000, 32'h0);
    addVec(0, 10, 32'h0,        32'h0000_0F5F, 32'hFFFF_0000, 32'h4242_4242);
    addVec(1, 0,  32'h1234_5678, 32'h1234_5678, 32'hFFFF_0000, 32'h0);
    addVec(0, 0,  32'h0,        32'h1234_5678, 32'hFFFF_0000, 32'h1234_5678);

    doReset();
    checkOutput("reset gpio_out", gpio_out, 32'hA5);
    checkOutput("reset gpio_oe", gpio_oe, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    checkOutput("reset rdata", reg_rdata, 32'h0);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // mid-operation reset restores everything on the next edge
    regWrite(5, 32'hFFFF_FFFF);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midreset gpio_out", gpio_out, 32'hA5);
    checkOutput("midreset gpio_oe", gpio_oe, 32'h0);
    checkOutput("midreset irq", {31'b0, irq}, 32'h0);
    checkOutput("midreset rdata", reg_rdata, 32'h0);
    reset = 1'b0;

`ifndef EHL_GPIO_DEBOUNCE_EN
    // ---------------- rising edge on bit 3 ----------------
    doReset();
    regWrite(5, 32'h8);
    regWrite(6, 32'h9);
    regWrite(7, 32'h8);
    regWrite(8, 32'h1);
    regWrite(10, 32'h9);
    tick(); tick();
    regRead(10, rd);
    checkOutput("edge cfg stat", rd & 32'h9, 32'h0);
    checkOutput("edge cfg irq", {31'b0, irq}, 32'h0);
    gpio_in = 32'h8;
    tick(); tick();
    reg_rd = 1'b1; reg_addr = 10;
    tick();
    checkOutput("rise stat edge2", {31'b0, reg_rdata[3]}, 32'h0);
    checkOutput("rise irq edge3", {31'b0, irq}, 32'h0);
    tick();
    reg_rd = 1'b0;
    checkOutput("rise stat edge3", {31'b0, reg_rdata[3]}, 32'h1);
    checkOutput("rise irq edge4", {31'b0, irq}, 32'h1);
    regWrite(10, 32'h8);
    checkOutput("w1c irq same edge", {31'b0, irq}, 32'h1);
    tick();
    checkOutput("w1c irq next edge", {31'b0, irq}, 32'h0);
    gpio_in = 32'h0;
    repeat (6) tick();
    regRead(10, rd);
    checkOutput("fall no event", {31'b0, rd[3]}, 32'h0);
    checkOutput("fall irq", {31'b0, irq}, 32'h0);

    // ---------------- both edges on bit 0 ----------------
    gpio_in = 32'h1;
    repeat (5) tick();
    regRead(10, rd);
    checkOutput("both rise", {31'b0, rd[0]}, 32'h1);
    regWrite(10, 32'h1);
    regRead(10, rd);
    checkOutput("both cleared", {31'b0, rd[0]}, 32'h0);
    gpio_in = 32'h0;
    repeat (5) tick();
    regRead(10, rd);
    checkOutput("both fall", {31'b0, rd[0]}, 32'h1);
    regWrite(10, 32'h1);
    regRead(10, rd);
    checkOutput("both cleared2", {31'b0, rd[0]}, 32'h0);
    gpio_in = 32'h1;
    tick(); tick();
    regWrite(10, 32'h1);
    regRead(10, rd);
    checkOutput("set beats w1c", {31'b0, rd[0]}, 32'h1);

    // ---------------- level-low on bit 7 ----------------
    regWrite(5, 32'h80);
    regWrite(10, 32'h80);
    regRead(10, rd);
    checkOutput("level resets", {31'b0, rd[7]}, 32'h1);
    checkOutput("level irq", {31'b0, irq}, 32'h1);
    gpio_in = 32'h81;
    repeat (4) tick();
    regWrite(10, 32'h80);
    regRead(10, rd);
    checkOutput("level released", {31'b0, rd[7]}, 32'h0);
    checkOutput("level irq falls", {31'b0, irq}, 32'h0);

    // ---------------- pin high through reset ----------------
    gpio_in = 32'h2;
    doReset();
    regWrite(7, 32'h2);
    regWrite(6, 32'h2);
    regWrite(10, 32'h2);
    regRead(10, rd);
    checkOutput("arm blocks rise", {31'b0, rd[1]}, 32'h0);
    repeat (5) tick();
    regRead(10, rd);
    checkOutput("arm hold", {31'b0, rd[1]}, 32'h0);
    gpio_in = 32'h0;
    repeat (5) tick();
    gpio_in = 32'h2;
    repeat (5) tick();
    regRead(10, rd);
    checkOutput("armed rise", {31'b0, rd[1]}, 32'h1);

    // ---------------- randomized against the model ----------------
    gpio_in = $urandom;
    doReset();
    m_out = 32'hA5; m_dir = 0; m_en = 0; m_type = 0; m_pol = 0; m_both = 0;
    m_stat = 0; m_rdata = 0; m_irq = 1'b0;
    pin_hist.delete();
    pin_hist.push_back(32'h0);
    for (int n = 1; n <= 400; n++) begin
      int op;
      gpio_in   = gpio_in ^ ($urandom & $urandom & $urandom);
      op        = $urandom_range(0, 3);
      reg_wr    = (op == 1) || (op == 2);
      reg_rd    = (op == 2) || (op == 3);
      reg_addr  = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      reg_wdata = $urandom;
      pin_hist.push_back(gpio_in);
      modelStep(n, reg_wr, reg_rd, reg_addr, reg_wdata);
      tick();
      checkOutput($sformatf("rand%0d gpio_out", n), gpio_out, m_out);
      checkOutput($sformatf("rand%0d gpio_oe", n), gpio_oe, m_dir);
      checkOutput($sformatf("rand%0d irq", n), {31'b0, irq}, {31'b0, m_irq});
      checkOutput($sformatf("rand%0d rdata", n), reg_rdata, m_rdata);
    end
    reg_wr = 1'b0; reg_rd = 1'b0;
`else
    // ---------------- debounce on bit 2 ----------------
    gpio_in = 32'h0;
    doReset();
    regWrite(6, 32'h4);
    regWrite(7, 32'h4);
    regWrite(10, 32'hFFFF_FFFF);
    repeat (5) tick();
    regRead(10, rd);
    checkOutput("db cfg stat", {31'b0, rd[2]}, 32'h0);
    reg_rd = 1'b1; reg_addr = 9;
    gpio_in = 32'h4;
    repeat (10) tick();
    gpio_in = 32'h0;
    for (int k = 0; k < 30; k++) begin
      tick();
      checkOutput($sformatf("db short IN k%0d", k), {31'b0, reg_rdata[2]}, 32'h0);
    end
    reg_addr = 10;
    tick();
    checkOutput("db short stat", {31'b0, reg_rdata[2]}, 32'h0);
    reg_addr = 9;
    repeat (5) tick();
    gpio_in = 32'h4;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == SYNC_STAGES + DEBOUNCE_CNT)
        checkOutput("db long IN before", {31'b0, reg_rdata[2]}, 32'h0);
      if (k == SYNC_STAGES + DEBOUNCE_CNT + 1)
        checkOutput("db long IN after", {31'b0, reg_rdata[2]}, 32'h1);
    end
    reg_rd = 1'b0;
    gpio_in = 32'h0;
    repeat (3) tick();
    regRead(10, rd);
    checkOutput("db long stat", {31'b0, rd[2]}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
